alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 16: general registers driven by one-hot Rin/Rout; legal range 2..16.
REQ-002 Parameter ALU_OP_MIN, default 3: lowest opcode treated as a register-register ALU op.
REQ-003 Parameter ALU_OP_MAX, default 12: highest opcode treated as a register-register ALU op.
REQ-004 Clock  in  1  single clock; all state changes on rising edge.
REQ-005 Clear  in  1  reset, asynchronous, active-high.
REQ-006 Start  in  1  request one fetch+execute sequence; sampled only in IDLE.
REQ-007 IR  in  32  datapath IR contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-008 PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath bus/load strobes.
REQ-009 Rout, Rin  out  NUM_REGS each  one-hot register bus-drive / load selects.
REQ-010 Alu_op  out  5  ALU operation code presented to the ALU.
REQ-011 Busy  out  1  high in T0..T5.
REQ-012 Done  out  1  one-cycle pulse on completion.
REQ-013 Illegal  out  1  sticky flag: last instruction not executable.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, DONE; outputs decode from present state and IR only.
REQ-015 IDLE: all strobes 0; Start=1 -> T0 next edge, Illegal cleared on that edge; Start=0 -> stay.
REQ-016 T0: PCout, MARin, IncPC, Zin = 1; -> T1.
REQ-017 T1: Zlowout, PCin, Read, MDRin = 1; -> T2 (see REQ-027).
REQ-018 T2: MDRout, IRin = 1; -> T3.
REQ-019 T3: if opcode in [ALU_OP_MIN, ALU_OP_MAX] and Ra, Rb, Rc < NUM_REGS: Rout[Rb], Yin = 1, -> T4; else no strobes, Illegal set, -> IDLE with no Done.
REQ-020 T4: Rout[Rc], Zin = 1, Alu_op = opcode; -> T5.
REQ-021 T5: Zlowout, Rin[Ra] = 1; -> DONE.
REQ-022 DONE: Done = 1, all strobes 0; -> IDLE; legal sequence latency Start-sample to Done = 7 cycles.
REQ-023 Alu_op SHALL be 0 in every state except T4.
REQ-024 At most one bit of Rout and of Rin SHALL be high in any cycle; Ra=Rb=Rc permitted.
REQ-025 Start outside IDLE SHALL be ignored; not queued.

Reset
REQ-026 Clear=1 SHALL immediately force IDLE, all outputs including Illegal to 0, regardless of state; Clear takes priority over simultaneous Start; first Start sampled on first edge with Clear low.

Configuration
REQ-027 Macro SEQ_MEM_WAIT_EN: when defined, input Mem_ready (1 bit) exists; T1 holds its strobes and stays in T1 until a cycle with Mem_ready=1, then -> T2; Clear aborts the wait. When undefined, no Mem_ready port and T1 lasts exactly one cycle.

Verification
REQ-028 Clear, Start pulse, IR=32'h4A920000 (AND R5,R2,R4): T3 Rout=bit2+Yin; T4 Rout=bit4, Alu_op=9; T5 Rin=bit5; Done at cycle 7; Illegal=0.
REQ-029 IR=32'h18000000 (opcode 3, Ra=Rb=Rc=0): Rout=bit0 in T3 and T4, Rin=bit0 in T5, Alu_op=3.
REQ-030 IR opcode 31: T3 drives no strobes, Illegal=1, back to IDLE, no Done; next Start clears Illegal.
REQ-031 NUM_REGS=8, IR Rc=9: Illegal=1, no Rout/Rin asserted.
REQ-032 Clear asserted in T4: outputs 0 same cycle, IDLE; Start held high during Busy never restarts mid-sequence.
REQ-033 With SEQ_MEM_WAIT_EN, Mem_ready low 3 cycles: T1 strobes held 4 cycles, Done at cycle 10.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute control sequencer for a single-bus datapath.
// One Start request runs T0..T5 (fetch, decode, register-register ALU op,
// write-back) and finishes with a one-cycle Done pulse. Instructions whose
// opcode lies outside [ALU_OP_MIN, ALU_OP_MAX], or whose register fields
// name a register that does not exist, abort in T3 and set the sticky
// Illegal flag instead.
// Optional build macro SEQ_MEM_WAIT_EN adds a Mem_ready input; T1 then holds
// its strobes until memory reports ready.
module alu_sequencer #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ALU_OP_MIN = 3,
  parameter int unsigned ALU_OP_MAX = 12
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Start,
`ifdef SEQ_MEM_WAIT_EN
  input  logic                Mem_ready,
`endif
  input  logic [31:0]         IR,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [4:0]          Alu_op,
  output logic                Busy,
  output logic                Done,
  output logic                Illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       legal;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  // Register index to one-hot select; indices beyond NUM_REGS give no select.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sel[i] = (idx == 4'(i));
    end
    return sel;
  endfunction

  // Executability of the instruction currently held in IR.
  always_comb begin
    legal = (32'(opcode) >= ALU_OP_MIN) && (32'(opcode) <= ALU_OP_MAX) &&
            (32'(ra) < NUM_REGS) && (32'(rb) < NUM_REGS) &&
            (32'(rc) < NUM_REGS);
  end

  // Next-state and sticky-flag logic.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_T0;
          illegal_d = 1'b0;
        end
      end
      S_T0: state_d = S_T1;
      S_T1: begin
`ifdef SEQ_MEM_WAIT_EN
        if (Mem_ready) begin
          state_d = S_T2;
        end
`else
        state_d = S_T2;
`endif
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (legal) begin
          state_d = S_T4;
        end else begin
          state_d   = S_IDLE;
          illegal_d = 1'b1;
        end
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and Illegal flag registers; Clear aborts any sequence at once.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode from present state and IR fields.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Rout    = '0;
    Rin     = '0;
    Alu_op  = '0;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (legal) begin
          Rout = reg_sel(rb);
          Yin  = 1'b1;
        end
      end
      S_T4: begin
        Rout   = reg_sel(rc);
        Zin    = 1'b1;
        Alu_op = opcode;
      end
      S_T5: begin
        Zlowout = 1'b1;
        Rin     = reg_sel(ra);
      end
      default: ;
    endcase
  end

  // Status outputs.
  always_comb begin
    Busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    Done    = (state_q == S_DONE);
    Illegal = illegal_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer: a 16-register instance and an
// 8-register instance share all inputs; outputs are checked 1 time unit
// after each rising edge against hand-computed vectors.
module tb_alu_sequencer;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        Start;
  logic [31:0] IR;
`ifdef SEQ_MEM_WAIT_EN
  logic        Mem_ready;
`endif

  logic a_pcout, a_zlowout, a_mdrout, a_marin, a_zin, a_pcin, a_mdrin;
  logic a_irin, a_yin, a_incpc, a_read, a_busy, a_done, a_ill;
  logic [15:0] a_rout, a_rin;
  logic [4:0]  a_alu;

  logic b_pcout, b_zlowout, b_mdrout, b_marin, b_zin, b_pcin, b_mdrin;
  logic b_irin, b_yin, b_incpc, b_read, b_busy, b_done, b_ill;
  logic [7:0]  b_rout, b_rin;
  logic [4:0]  b_alu;

  logic [50:0] obs16, obs8;

  int n_cmp = 0;
  int n_err = 0;

  // Strobe vector bit order: PCout Zlowout MDRout MARin Zin PCin MDRin IRin Yin IncPC Read
  localparam logic [10:0] B_PCOUT   = 11'd1 << 10;
  localparam logic [10:0] B_ZLOWOUT = 11'd1 << 9;
  localparam logic [10:0] B_MDROUT  = 11'd1 << 8;
  localparam logic [10:0] B_MARIN   = 11'd1 << 7;
  localparam logic [10:0] B_ZIN     = 11'd1 << 6;
  localparam logic [10:0] B_PCIN    = 11'd1 << 5;
  localparam logic [10:0] B_MDRIN   = 11'd1 << 4;
  localparam logic [10:0] B_IRIN    = 11'd1 << 3;
  localparam logic [10:0] B_YIN     = 11'd1 << 2;
  localparam logic [10:0] B_INCPC   = 11'd1 << 1;
  localparam logic [10:0] B_READ    = 11'd1;

  localparam logic [10:0] ST_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [10:0] ST_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [10:0] ST_T2 = B_MDROUT | B_IRIN;
  localparam logic [10:0] ST_T3 = B_YIN;
  localparam logic [10:0] ST_T4 = B_ZIN;
  localparam logic [10:0] ST_T5 = B_ZLOWOUT;

  alu_sequencer #(.NUM_REGS(16), .ALU_OP_MIN(3), .ALU_OP_MAX(12)) u_dut16 (
    .Clock(Clock), .Clear(Clear), .Start(Start),
`ifdef SEQ_MEM_WAIT_EN
    .Mem_ready(Mem_ready),
`endif
    .IR(IR),
    .PCout(a_pcout), .Zlowout(a_zlowout), .MDRout(a_mdrout), .MARin(a_marin),
    .Zin(a_zin), .PCin(a_pcin), .MDRin(a_mdrin), .IRin(a_irin), .Yin(a_yin),
    .IncPC(a_incpc), .Read(a_read), .Rout(a_rout), .Rin(a_rin), .Alu_op(a_alu),
    .Busy(a_busy), .Done(a_done), .Illegal(a_ill)
  );

  alu_sequencer #(.NUM_REGS(8), .ALU_OP_MIN(3), .ALU_OP_MAX(12)) u_dut8 (
    .Clock(Clock), .Clear(Clear), .Start(Start),
`ifdef SEQ_MEM_WAIT_EN
    .Mem_ready(Mem_ready),
`endif
    .IR(IR),
    .PCout(b_pcout), .Zlowout(b_zlowout), .MDRout(b_mdrout), .MARin(b_marin),
    .Zin(b_zin), .PCin(b_pcin), .MDRin(b_mdrin), .IRin(b_irin), .Yin(b_yin),
    .IncPC(b_incpc), .Read(b_read), .Rout(b_rout), .Rin(b_rin), .Alu_op(b_alu),
    .Busy(b_busy), .Done(b_done), .Illegal(b_ill)
  );

  assign obs16 = {a_pcout, a_zlowout, a_mdrout, a_marin, a_zin, a_pcin, a_mdrin,
                  a_irin, a_yin, a_incpc, a_read, a_rout, a_rin, a_alu,
                  a_busy, a_done, a_ill};
  assign obs8  = {b_pcout, b_zlowout, b_mdrout, b_marin, b_zin, b_pcin, b_mdrin,
                  b_irin, b_yin, b_incpc, b_read, 8'h00, b_rout, 8'h00, b_rin,
                  b_alu, b_busy, b_done, b_ill};

  always #5 Clock = ~Clock;

  function automatic logic [50:0] ev(input logic [10:0] st, input logic [15:0] rout,
                                     input logic [15:0] rin, input logic [4:0] alu,
                                     input logic busy, input logic done, input logic ill);
    return {st, rout, rin, alu, busy, done, ill};
  endfunction

  task automatic chk(input string tag, input logic [50:0] obs, input logic [50:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Full legal sequence from IDLE: Start pulse, then every state through DONE and back to IDLE.
  task automatic run_legal(input string nm, input logic [31:0] ir,
                           input logic [15:0] rb1h, input logic [15:0] rc1h,
                           input logic [15:0] ra1h, input logic [4:0] op);
    IR = ir;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk({nm, "_T0"}, obs16, ev(ST_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk({nm, "_T1"}, obs16, ev(ST_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk({nm, "_T2"}, obs16, ev(ST_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk({nm, "_T3"}, obs16, ev(ST_T3, rb1h, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk({nm, "_T4"}, obs16, ev(ST_T4, rc1h, 16'h0, op, 1'b1, 1'b0, 1'b0));
    tick();
    chk({nm, "_T5"}, obs16, ev(ST_T5, 16'h0, ra1h, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk({nm, "_DONE"}, obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0));
    tick();
    chk({nm, "_IDLE"}, obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    Clear = 1'b1;
    Start = 1'b0;
    IR    = 32'h0;
`ifdef SEQ_MEM_WAIT_EN
    Mem_ready = 1'b1;
`endif
    #1;
    chk("reset16", obs16, '0);
    chk("reset8", obs8, '0);

    // Clear wins over a simultaneous Start.
    Start = 1'b1;
    tick();
    chk("clear_prio", obs16, '0);
    Clear = 1'b0;
    Start = 1'b0;
    tick();

    // AND R5,R2,R4
    run_legal("and_r5_r2_r4", 32'h4A920000, 16'h0004, 16'h0010, 16'h0020, 5'd9);
    // opcode 3, Ra=Rb=Rc=0
    run_legal("op3_r0", 32'h18000000, 16'h0001, 16'h0001, 16'h0001, 5'd3);
    // opcode 12 (upper bound), Ra=15 Rb=14 Rc=13
    run_legal("op12_r15", 32'h67F68000, 16'h4000, 16'h2000, 16'h8000, 5'd12);

    // Opcode 31: abort in T3, Illegal set, no Done.
    IR = 32'hF8000000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    chk("op31_T3", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("op31_idle", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("op31_sticky", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    // Next Start clears Illegal.
    IR = 32'h18000000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("ill_cleared_T0", obs16, ev(ST_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    repeat (7) tick();
    chk("after_restart_idle", obs16, '0);

    // Opcode 2 (below lower bound); Clear then wipes Illegal.
    IR = 32'h10000000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    chk("op2_T3", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("op2_idle", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    Clear = 1'b1;
    #1;
    chk("clear_illegal", obs16, '0);
    Clear = 1'b0;
    tick();

    // Opcode 13 (just above upper bound).
    IR = 32'h68000000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    chk("op13_T3", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("op13_idle", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1));

    // Rc=9: legal for 16 registers, illegal for 8. opcode 5, Ra=1, Rb=2.
    IR = 32'h28948000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (3) tick();
    chk("rc9_T3_16", obs16, ev(ST_T3, 16'h0004, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    chk("rc9_T3_8", obs8, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("rc9_T4_16", obs16, ev(ST_T4, 16'h0200, 16'h0, 5'd5, 1'b1, 1'b0, 1'b0));
    chk("rc9_idle_8", obs8, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("rc9_T5_16", obs16, ev(ST_T5, 16'h0, 16'h0002, 5'd0, 1'b1, 1'b0, 1'b0));
    chk("rc9_noRin_8", obs8, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("rc9_DONE_16", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0));
    chk("rc9_nodone_8", obs8, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1));
    tick();

    // Start held high: no restart while busy, re-sampled only back in IDLE.
    IR = 32'h4A920000;
    Start = 1'b1;
    tick();
    chk("hold_T0", obs16, ev(ST_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("hold_T1", obs16, ev(ST_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    repeat (4) tick();
    chk("hold_T5", obs16, ev(ST_T5, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("hold_DONE", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0));
    tick();
    chk("hold_IDLE", obs16, '0);
    tick();
    chk("hold_T0_again", obs16, ev(ST_T0, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    repeat (4) tick();
    chk("hold_T4", obs16, ev(ST_T4, 16'h0010, 16'h0, 5'd9, 1'b1, 1'b0, 1'b0));
    // Clear in T4 drops everything in the same cycle.
    #1;
    Clear = 1'b1;
    #1;
    chk("clear_in_T4", obs16, '0);
    tick();
    chk("clear_held_start", obs16, '0);
    Clear = 1'b0;
    Start = 1'b0;
    tick();
    chk("post_clear_idle", obs16, '0);

`ifdef SEQ_MEM_WAIT_EN
    // Mem_ready low for three T1 cycles: T1 lasts four cycles, Done at cycle 10.
    IR = 32'h4A920000;
    Mem_ready = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("wait_T1_c1", obs16, ev(ST_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("wait_T1_c2", obs16, ev(ST_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("wait_T1_c3", obs16, ev(ST_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("wait_T1_c4", obs16, ev(ST_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    Mem_ready = 1'b1;
    tick();
    chk("wait_T2", obs16, ev(ST_T2, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    repeat (3) tick();
    chk("wait_T5", obs16, ev(ST_T5, 16'h0, 16'h0020, 5'd0, 1'b1, 1'b0, 1'b0));
    tick();
    chk("wait_DONE_c10", obs16, ev(11'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b0));
    tick();
    // Clear aborts a pending memory wait.
    Mem_ready = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (2) tick();
    chk("abort_wait_T1", obs16, ev(ST_T1, 16'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0));
    Clear = 1'b1;
    #1;
    chk("abort_wait_clear", obs16, '0);
    Clear = 1'b0;
    Mem_ready = 1'b1;
    tick();
    chk("abort_wait_idle", obs16, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
